// File: rtl/gb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gb_irq_ctrl
//  Description : Gameboy interrupt controller. Latches single-cycle interrupt
//                pulses into IF (0xFF0F), masks them with IE (0xFFFF), and
//                drives the CPU interrupt request, HALT wake and the dispatch
//                vector latched on acknowledge. IME lives in the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_irq_ctrl (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       irq_vblank,
  input  logic       irq_lcd,
  input  logic       irq_timer,
  input  logic       irq_serial,
  input  logic       irq_joypad,
  input  logic       cpu_sel_if,
  input  logic       cpu_sel_ie,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       cpu_int,
  output logic       halt_wake,
  input  logic       cpu_int_ack,
  output logic [7:0] cpu_int_vec
);

  // Dispatch FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACKED = 1'b1;

  // Base of the interrupt vector table; each source is 8 bytes apart
  localparam logic [7:0] VEC_BASE   = 8'h40;
  localparam logic [7:0] VEC_CANCEL = 8'h00;

  // Architectural state
  logic [4:0] if_r;
  logic [7:0] ie_r;
  logic [7:0] vec_r;
  logic [0:0] state_r;

  // Combinational helpers
  logic [4:0] src;
  logic [4:0] pend;
  logic       pend_any;
  logic [2:0] ack_idx;
  logic [4:0] ack_mask;
  logic [7:0] ack_vec;
  logic       wr_if;
  logic       wr_ie;
  logic       do_ack;
  logic [4:0] if_next;
  logic [0:0] state_next;

  // Source pulses packed in IF bit order (bit 0 = VBlank, highest priority)
  assign src = {irq_joypad, irq_serial, irq_timer, irq_lcd, irq_vblank};

  assign pend     = if_r & ie_r[4:0];
  assign pend_any = |pend;

  assign cpu_int     = pend_any;
  assign halt_wake   = pend_any;
  assign cpu_int_vec = vec_r;

  // Strobes only take effect on clock-enabled cycles
  assign wr_if  = ce & cpu_wr & cpu_sel_if;
  assign wr_ie  = ce & cpu_wr & cpu_sel_ie;
  assign do_ack = ce & cpu_int_ack;

  // Priority encoder: scanning from bit 4 down leaves the lowest pending index
  always_comb begin
    ack_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) begin
        ack_idx = 3'(i);
      end
    end
  end

  // One-hot of the bit to clear; empty when nothing is pending (cancelled dispatch)
  assign ack_mask = pend_any ? (5'b00001 << ack_idx) : 5'b00000;

  // Vector of the winning source, or 0x00 when the dispatch is cancelled
  assign ack_vec = pend_any ? (VEC_BASE + {2'b00, ack_idx, 3'b000}) : VEC_CANCEL;

  // IF next value: write replaces, ack clears on pre-update pend, pulses win last
  always_comb begin
    if_next = if_r;
    if (wr_if) begin
      if_next = cpu_di[4:0];
    end
    if (do_ack) begin
      if_next = if_next & ~ack_mask;
    end
    if (ce) begin
      if_next = if_next | src;
    end
  end

  // Dispatch FSM next state: an ack always lands in ACKED, otherwise fall back
  always_comb begin
    state_next = state_r;
    if (do_ack) begin
      state_next = ST_ACKED;
    end else if (ce && state_r == ST_ACKED) begin
      state_next = ST_IDLE;
    end
  end

  // IF / IE / vector / FSM registers; reset overrides everything including ce
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      if_r    <= 5'd0;
      ie_r    <= 8'd0;
      vec_r   <= VEC_CANCEL;
      state_r <= ST_IDLE;
    end else begin
      if_r    <= if_next;
      state_r <= state_next;
      if (wr_ie) begin
        ie_r <= cpu_di;
      end
      if (do_ack) begin
        vec_r <= ack_vec;
      end
    end
  end

  // Register read mux; unused IF bits read as ones, unselected bus reads 0xFF
  always_comb begin
    cpu_do = 8'hFF;
    if (cpu_sel_if) begin
      cpu_do = {3'b111, if_r};
    end else if (cpu_sel_ie) begin
      cpu_do = ie_r;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_irq_ctrl
//  Description : Directed self-checking bench for gb_irq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_irq_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce;
  logic       irq_vblank, irq_lcd, irq_timer, irq_serial, irq_joypad;
  logic       cpu_sel_if, cpu_sel_ie, cpu_wr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       cpu_int, halt_wake, cpu_int_ack;
  logic [7:0] cpu_int_vec;

  int checks = 0;
  int fails  = 0;

  gb_irq_ctrl dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce          (ce),
    .irq_vblank  (irq_vblank),
    .irq_lcd     (irq_lcd),
    .irq_timer   (irq_timer),
    .irq_serial  (irq_serial),
    .irq_joypad  (irq_joypad),
    .cpu_sel_if  (cpu_sel_if),
    .cpu_sel_ie  (cpu_sel_ie),
    .cpu_wr      (cpu_wr),
    .cpu_di      (cpu_di),
    .cpu_do      (cpu_do),
    .cpu_int     (cpu_int),
    .halt_wake   (halt_wake),
    .cpu_int_ack (cpu_int_ack),
    .cpu_int_vec (cpu_int_vec)
  );

  always #5 clk_sys = ~clk_sys;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // One clock with the given stimulus; inputs return idle afterwards
  task automatic cycle(input logic ce_v, input logic w_if, input logic w_ie,
                       input logic [7:0] di, input logic [4:0] pulses, input logic ack);
    ce          = ce_v;
    cpu_wr      = w_if | w_ie;
    cpu_sel_if  = w_if;
    cpu_sel_ie  = w_ie;
    cpu_di      = di;
    {irq_joypad, irq_serial, irq_timer, irq_lcd, irq_vblank} = pulses;
    cpu_int_ack = ack;
    @(posedge clk_sys);
    #1;
    ce          = 1'b1;
    cpu_wr      = 1'b0;
    cpu_sel_if  = 1'b0;
    cpu_sel_ie  = 1'b0;
    cpu_di      = 8'h00;
    {irq_joypad, irq_serial, irq_timer, irq_lcd, irq_vblank} = 5'd0;
    cpu_int_ack = 1'b0;
  endtask

  task automatic read_if(output logic [7:0] v);
    cpu_sel_if = 1'b1; cpu_sel_ie = 1'b0; #1; v = cpu_do; cpu_sel_if = 1'b0;
  endtask

  task automatic read_ie(output logic [7:0] v);
    cpu_sel_if = 1'b0; cpu_sel_ie = 1'b1; #1; v = cpu_do; cpu_sel_ie = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    reset = 1'b1; ce = 1'b1; cpu_wr = 1'b0; cpu_sel_if = 1'b0; cpu_sel_ie = 1'b0;
    cpu_di = 8'h00; cpu_int_ack = 1'b0;
    {irq_joypad, irq_serial, irq_timer, irq_lcd, irq_vblank} = 5'd0;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset = 1'b0;

    // Reset values
    check("rst_int", {7'd0, cpu_int}, 8'h00);
    check("rst_wake", {7'd0, halt_wake}, 8'h00);
    check("rst_vec", cpu_int_vec, 8'h00);
    read_if(rd); check("rst_if", rd, 8'hE0);
    read_ie(rd); check("rst_ie", rd, 8'h00);
    #1; check("rst_nosel", cpu_do, 8'hFF);

    // Timer interrupt, then acknowledge
    cycle(1, 0, 1, 8'h04, 5'b00000, 0);
    cycle(1, 0, 0, 8'h00, 5'b00100, 0);
    read_if(rd); check("t1_if", rd, 8'hE4);
    check("t1_int", {7'd0, cpu_int}, 8'h01);
    cycle(1, 0, 0, 8'h00, 5'b00000, 1);
    check("t1_vec", cpu_int_vec, 8'h50);
    read_if(rd); check("t1_if_ack", rd, 8'hE0);
    check("t1_int_ack", {7'd0, cpu_int}, 8'h00);

    // Priority: VBlank before joypad
    cycle(1, 0, 1, 8'h1F, 5'b00000, 0);
    cycle(1, 0, 0, 8'h00, 5'b10001, 0);
    cycle(1, 0, 0, 8'h00, 5'b00000, 1);
    check("t2_vec0", cpu_int_vec, 8'h40);
    read_if(rd); check("t2_if0", rd, 8'hF0);
    cycle(1, 0, 0, 8'h00, 5'b00000, 1);
    check("t2_vec1", cpu_int_vec, 8'h60);
    read_if(rd); check("t2_if1", rd, 8'hE0);

    // Masked serial interrupt, then enabled
    cycle(1, 0, 1, 8'h00, 5'b00000, 0);
    cycle(1, 0, 0, 8'h00, 5'b01000, 0);
    read_if(rd); check("t3_if", rd, 8'hE8);
    check("t3_int", {7'd0, cpu_int}, 8'h00);
    check("t3_wake", {7'd0, halt_wake}, 8'h00);
    cycle(1, 0, 1, 8'h08, 5'b00000, 0);
    check("t3_int_en", {7'd0, cpu_int}, 8'h01);
    check("t3_wake_en", {7'd0, halt_wake}, 8'h01);

    // Set beats write-clear and ack-clear in the same cycle
    cycle(1, 0, 1, 8'h04, 5'b00000, 0);
    cycle(1, 1, 0, 8'h00, 5'b00100, 0);
    read_if(rd); check("t4_wr_vs_set", rd, 8'hE4);
    cycle(1, 0, 0, 8'h00, 5'b00100, 1);
    read_if(rd); check("t4_ack_vs_set", rd, 8'hE4);
    check("t4_vec", cpu_int_vec, 8'h50);

    // Cancelled dispatch
    cycle(1, 1, 0, 8'h01, 5'b00000, 0);
    cycle(1, 0, 1, 8'h01, 5'b00000, 0);
    check("t5_int", {7'd0, cpu_int}, 8'h01);
    cycle(1, 0, 1, 8'h00, 5'b00000, 0);
    cycle(1, 0, 0, 8'h00, 5'b00000, 1);
    check("t5_vec", cpu_int_vec, 8'h00);
    read_if(rd); check("t5_if", rd, 8'hE1);

    // ce low freezes state despite strobes and pulses
    cycle(0, 1, 0, 8'h00, 5'b00010, 0);
    read_if(rd); check("ce0_if", rd, 8'hE1);
    cycle(0, 0, 1, 8'h01, 5'b00000, 0);
    check("ce0_int", {7'd0, cpu_int}, 8'h00);
    cycle(1, 0, 1, 8'h01, 5'b00000, 0);
    cycle(0, 0, 0, 8'h00, 5'b00000, 1);
    check("ce0_vec", cpu_int_vec, 8'h00);
    read_if(rd); check("ce0_if_ack", rd, 8'hE1);

    // Full-width writes and reset mid-dispatch
    cycle(1, 0, 1, 8'hFF, 5'b00000, 0);
    read_ie(rd); check("t6_ie", rd, 8'hFF);
    cycle(1, 1, 0, 8'hFF, 5'b00000, 0);
    read_if(rd); check("t6_if", rd, 8'hFF);
    check("t6_int", {7'd0, cpu_int}, 8'h01);
    cycle(1, 0, 0, 8'h00, 5'b00000, 1);
    check("t6_vec", cpu_int_vec, 8'h40);
    reset = 1'b1;
    cycle(1, 0, 0, 8'h00, 5'b11111, 1);
    reset = 1'b0;
    check("t6_rst_int", {7'd0, cpu_int}, 8'h00);
    check("t6_rst_wake", {7'd0, halt_wake}, 8'h00);
    check("t6_rst_vec", cpu_int_vec, 8'h00);
    read_if(rd); check("t6_rst_if", rd, 8'hE0);
    read_ie(rd); check("t6_rst_ie", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
